// File: rtl/cm_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cm_timing_ctrl_if
// Purpose  : Config write port of the camera-module timing controller.
// Revision : 1.0
// ============================================================================
interface cm_timing_ctrl_if #(
  parameter int FP_WIDTH = 11
);
  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic [FP_WIDTH-1:0] cfg_wdata;
  logic                cfg_ack;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_ack);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_ack);
endinterface
`default_nettype wire

// File: rtl/cm_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cm_timing_ctrl
// Purpose  : Line/frame timing for the pixel counter with frame-boundary
//            shadowed config. CM_TIMING_STATUS_EN adds frame_cnt and cfg_err.
// Revision : 1.0
// ============================================================================
module cm_timing_ctrl #(
  parameter int          FP_WIDTH     = 11,
  parameter int          BP_WIDTH     = 11,
  parameter int          V_WIDTH      = 10,
  parameter int unsigned RST_LINE_LEN = 640,
  parameter int unsigned RST_H_BLANK  = 16,
  parameter int unsigned RST_BP       = 0,
  parameter int unsigned RST_FP       = 640,
  parameter int unsigned RST_V_TOTAL  = 480,
  parameter int unsigned RST_V_START  = 0,
  parameter int unsigned RST_V_END    = 480
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 enable,
  cm_timing_ctrl_if.slave     cfg,
  output logic                line_sync,
  output logic [BP_WIDTH-1:0] back_porch,
  output logic [FP_WIDTH-1:0] front_porch,
  output logic [V_WIDTH-1:0]  line_num,
  output logic                frame_start,
  output logic                line_end,
  output logic                busy
`ifdef CM_TIMING_STATUS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic                cfg_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  localparam logic [FP_WIDTH-1:0] c_fp_one = FP_WIDTH'(1);
  localparam logic [V_WIDTH-1:0]  c_v_one  = V_WIDTH'(1);

  state_t              state_q, state_d;
  logic [FP_WIDTH-1:0] h_cnt_q, h_cnt_d;
  logic [V_WIDTH-1:0]  line_num_q, line_num_d;
  logic                line_sync_q, line_sync_d;
  logic                frame_start_q, frame_start_d;
  logic                line_end_q, line_end_d;
  logic                cfg_ack_q, cfg_ack_d;
  logic                busy_q, busy_d;

  logic [FP_WIDTH-1:0] line_len_stg_q, line_len_stg_d, line_len_q, line_len_d;
  logic [FP_WIDTH-1:0] h_blank_stg_q, h_blank_stg_d, h_blank_q, h_blank_d;
  logic [BP_WIDTH-1:0] back_porch_stg_q, back_porch_stg_d, back_porch_q, back_porch_d;
  logic [FP_WIDTH-1:0] front_porch_stg_q, front_porch_stg_d, front_porch_q, front_porch_d;
  logic [V_WIDTH-1:0]  v_total_stg_q, v_total_stg_d, v_total_q, v_total_d;
  logic [V_WIDTH-1:0]  v_start_stg_q, v_start_stg_d, v_start_q, v_start_d;
  logic [V_WIDTH-1:0]  v_end_stg_q, v_end_stg_d, v_end_q, v_end_d;

  logic last_active, last_blank, last_line, commit;

`ifdef CM_TIMING_STATUS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        cfg_err_q, cfg_err_d;
`endif

  always_comb begin
    line_len_stg_d    = line_len_stg_q;
    h_blank_stg_d     = h_blank_stg_q;
    back_porch_stg_d  = back_porch_stg_q;
    front_porch_stg_d = front_porch_stg_q;
    v_total_stg_d     = v_total_stg_q;
    v_start_stg_d     = v_start_stg_q;
    v_end_stg_d       = v_end_stg_q;
    cfg_ack_d         = 1'b0;
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        3'd0:    line_len_stg_d    = FP_WIDTH'(cfg.cfg_wdata);
        3'd1:    h_blank_stg_d     = FP_WIDTH'(cfg.cfg_wdata);
        3'd2:    back_porch_stg_d  = BP_WIDTH'(cfg.cfg_wdata);
        3'd3:    front_porch_stg_d = FP_WIDTH'(cfg.cfg_wdata);
        3'd4:    v_total_stg_d     = V_WIDTH'(cfg.cfg_wdata);
        3'd5:    v_start_stg_d     = V_WIDTH'(cfg.cfg_wdata);
        3'd6:    v_end_stg_d       = V_WIDTH'(cfg.cfg_wdata);
        default: ;
      endcase
`ifdef CM_TIMING_STATUS_EN
      cfg_ack_d = 1'b1;
`else
      cfg_ack_d = (cfg.cfg_addr != 3'd7);
`endif
    end

    last_active = (h_cnt_q == line_len_q - c_fp_one);
    last_blank  = (h_cnt_q == h_blank_q - c_fp_one);
    last_line   = (line_num_q == v_total_q - c_v_one);
    // Commit sees this cycle's write, so a frame-end write is not lost.
    commit      = (state_q == ST_IDLE) ||
                  ((state_q == ST_BLANK) && last_blank && last_line);

    line_len_d    = line_len_q;
    h_blank_d     = h_blank_q;
    back_porch_d  = back_porch_q;
    front_porch_d = front_porch_q;
    v_total_d     = v_total_q;
    v_start_d     = v_start_q;
    v_end_d       = v_end_q;
    if (commit) begin
      line_len_d    = (line_len_stg_d == '0) ? c_fp_one : line_len_stg_d;
      h_blank_d     = (h_blank_stg_d == '0) ? c_fp_one : h_blank_stg_d;
      back_porch_d  = back_porch_stg_d;
      front_porch_d = front_porch_stg_d;
      v_total_d     = (v_total_stg_d == '0) ? c_v_one : v_total_stg_d;
      v_start_d     = v_start_stg_d;
      v_end_d       = v_end_stg_d;
    end

    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    line_num_d    = line_num_q;
    frame_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d       = ST_ACTIVE;
          h_cnt_d       = '0;
          line_num_d    = '0;
          frame_start_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (last_active) begin
          state_d = ST_BLANK;
          h_cnt_d = '0;
        end else begin
          h_cnt_d = h_cnt_q + c_fp_one;
        end
      end
      ST_BLANK: begin
        if (last_blank) begin
          h_cnt_d = '0;
          if (!last_line) begin
            state_d    = ST_ACTIVE;
            line_num_d = line_num_q + c_v_one;
          end else begin
            // enable only matters here, so a frame always runs to completion.
            line_num_d = '0;
            if (enable) begin
              state_d       = ST_ACTIVE;
              frame_start_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          h_cnt_d = h_cnt_q + c_fp_one;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        h_cnt_d    = '0;
        line_num_d = '0;
      end
    endcase

    line_sync_d = (state_d == ST_ACTIVE) && (line_num_d >= v_start_d) &&
                  (line_num_d < v_end_d);
    line_end_d  = (state_d == ST_BLANK) && (h_cnt_d == h_blank_d - c_fp_one);
    busy_d      = (state_d != ST_IDLE);

`ifdef CM_TIMING_STATUS_EN
    // The frame_start leaving IDLE is not counted; only wraps are.
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d && (state_q != ST_IDLE)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    cfg_err_d = cfg_err_q;
    if (commit && ((front_porch_d > line_len_d) ||
                   (32'(back_porch_d) >= 32'(front_porch_d)))) begin
      cfg_err_d = 1'b1;
    end
    if (cfg.cfg_we && (cfg.cfg_addr == 3'd7)) begin
      cfg_err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      h_cnt_q           <= '0;
      line_num_q        <= '0;
      line_sync_q       <= 1'b0;
      frame_start_q     <= 1'b0;
      line_end_q        <= 1'b0;
      cfg_ack_q         <= 1'b0;
      busy_q            <= 1'b0;
      line_len_stg_q    <= FP_WIDTH'(RST_LINE_LEN);
      h_blank_stg_q     <= FP_WIDTH'(RST_H_BLANK);
      back_porch_stg_q  <= BP_WIDTH'(RST_BP);
      front_porch_stg_q <= FP_WIDTH'(RST_FP);
      v_total_stg_q     <= V_WIDTH'(RST_V_TOTAL);
      v_start_stg_q     <= V_WIDTH'(RST_V_START);
      v_end_stg_q       <= V_WIDTH'(RST_V_END);
      line_len_q        <= FP_WIDTH'(RST_LINE_LEN);
      h_blank_q         <= FP_WIDTH'(RST_H_BLANK);
      back_porch_q      <= BP_WIDTH'(RST_BP);
      front_porch_q     <= FP_WIDTH'(RST_FP);
      v_total_q         <= V_WIDTH'(RST_V_TOTAL);
      v_start_q         <= V_WIDTH'(RST_V_START);
      v_end_q           <= V_WIDTH'(RST_V_END);
`ifdef CM_TIMING_STATUS_EN
      frame_cnt_q       <= '0;
      cfg_err_q         <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      h_cnt_q           <= h_cnt_d;
      line_num_q        <= line_num_d;
      line_sync_q       <= line_sync_d;
      frame_start_q     <= frame_start_d;
      line_end_q        <= line_end_d;
      cfg_ack_q         <= cfg_ack_d;
      busy_q            <= busy_d;
      line_len_stg_q    <= line_len_stg_d;
      h_blank_stg_q     <= h_blank_stg_d;
      back_porch_stg_q  <= back_porch_stg_d;
      front_porch_stg_q <= front_porch_stg_d;
      v_total_stg_q     <= v_total_stg_d;
      v_start_stg_q     <= v_start_stg_d;
      v_end_stg_q       <= v_end_stg_d;
      line_len_q        <= line_len_d;
      h_blank_q         <= h_blank_d;
      back_porch_q      <= back_porch_d;
      front_porch_q     <= front_porch_d;
      v_total_q         <= v_total_d;
      v_start_q         <= v_start_d;
      v_end_q           <= v_end_d;
`ifdef CM_TIMING_STATUS_EN
      frame_cnt_q       <= frame_cnt_d;
      cfg_err_q         <= cfg_err_d;
`endif
    end
  end

  assign cfg.cfg_ack   = cfg_ack_q;
  assign line_sync     = line_sync_q;
  assign back_porch    = back_porch_q;
  assign front_porch   = front_porch_q;
  assign line_num      = line_num_q;
  assign frame_start   = frame_start_q;
  assign line_end      = line_end_q;
  assign busy          = busy_q;
`ifdef CM_TIMING_STATUS_EN
  assign frame_cnt     = frame_cnt_q;
  assign cfg_err       = cfg_err_q;
`endif

endmodule
`default_nettype wire
